// File: rtl/alu_seq.sv
// Multi-cycle ALU behind valid/ready handshakes: logic/arith ops finish in one
// cycle, shifts move one bit per cycle and multiply runs a WIDTH-step shift-add.
module alu_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z
);

    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = SHW + 1;

    localparam logic [4:0] OP_ADD = 5'd0;
    localparam logic [4:0] OP_SUB = 5'd1;
    localparam logic [4:0] OP_AND = 5'd2;
    localparam logic [4:0] OP_OR  = 5'd3;
    localparam logic [4:0] OP_XOR = 5'd4;
    localparam logic [4:0] OP_NOT = 5'd5;
    localparam logic [4:0] OP_SLT = 5'd6;
    localparam logic [4:0] OP_SHL = 5'd7;
    localparam logic [4:0] OP_SHR = 5'd8;
    localparam logic [4:0] OP_SRA = 5'd9;
    localparam logic [4:0] OP_MUL = 5'd10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [WIDTH-1:0] z_nxt;
    logic [4:0]       op_r, op_nxt;
    logic [WIDTH-1:0] acc, acc_nxt;
    logic [WIDTH-1:0] mplier, mplier_nxt;
    logic [WIDTH-1:0] prod, prod_nxt;
    logic [WIDTH-1:0] prod_step;
    logic [WIDTH-1:0] shf_step;
    logic [SHW-1:0]   shamt;

    // Single-cycle result for every non-iterative opcode; undefined codes give 0.
    function automatic logic [WIDTH-1:0] alu_single(input logic [4:0]       f,
                                                    input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] b);
        logic signed [WIDTH-1:0] as;
        logic signed [WIDTH-1:0] bs;
        logic [WIDTH-1:0]        r;
        as = a;
        bs = b;
        case (f)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_NOT:  r = ~a;
            OP_SLT:  r = (as < bs) ? WIDTH'(1) : '0;
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] shift_one(input logic [4:0]       f,
                                                   input logic [WIDTH-1:0] a);
        logic [WIDTH-1:0] r;
        case (f)
            OP_SHL:  r = {a[WIDTH-2:0], 1'b0};
            OP_SHR:  r = {1'b0, a[WIDTH-1:1]};
            OP_SRA:  r = {a[WIDTH-1], a[WIDTH-1:1]};
            default: r = a;
        endcase
        return r;
    endfunction

    function automatic logic is_shift(input logic [4:0] f);
        return (f == OP_SHL) || (f == OP_SHR) || (f == OP_SRA);
    endfunction

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign shamt     = y[SHW-1:0];

    // Control state, counter and the presented result reset asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            z     <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            z     <= z_nxt;
        end
    end

    // Working operands are only meaningful while BUSY, so they carry no reset.
    always_ff @(posedge clk) begin
        op_r   <= op_nxt;
        acc    <= acc_nxt;
        mplier <= mplier_nxt;
        prod   <= prod_nxt;
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        z_nxt      = z;
        op_nxt     = op_r;
        acc_nxt    = acc;
        mplier_nxt = mplier;
        prod_nxt   = prod;
        prod_step  = mplier[0] ? (prod + acc) : prod;
        shf_step   = shift_one(op_r, acc);

        case (state)
            S_IDLE: begin
                if (in_valid) begin
                    op_nxt = op;
                    if (is_shift(op)) begin
                        if (shamt == '0) begin
                            z_nxt     = x;
                            state_nxt = S_DONE;
                        end else begin
                            acc_nxt   = x;
                            cnt_nxt   = CW'(shamt);
                            state_nxt = S_BUSY;
                        end
                    end else if (op == OP_MUL) begin
                        acc_nxt    = x;
                        mplier_nxt = y;
                        prod_nxt   = '0;
                        cnt_nxt    = CW'(WIDTH);
                        state_nxt  = S_BUSY;
                    end else begin
                        z_nxt     = alu_single(op, x, y);
                        state_nxt = S_DONE;
                    end
                end
            end

            S_BUSY: begin
                cnt_nxt = cnt - CW'(1);
                if (op_r == OP_MUL) begin
                    // acc holds the multiplicand, shifted up as the multiplier drains.
                    prod_nxt   = prod_step;
                    acc_nxt    = {acc[WIDTH-2:0], 1'b0};
                    mplier_nxt = {1'b0, mplier[WIDTH-1:1]};
                    if (cnt == CW'(1)) begin
                        z_nxt     = prod_step;
                        state_nxt = S_DONE;
                    end
                end else begin
                    acc_nxt = shf_step;
                    if (cnt == CW'(1)) begin
                        z_nxt     = shf_step;
                        state_nxt = S_DONE;
                    end
                end
            end

            S_DONE: begin
                if (out_ready) begin
                    state_nxt = S_IDLE;
                end
            end

            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq: the driver pushes expected results and
// output cycles into a scoreboard, a monitor pops them as results appear.
module tb_alu_seq;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [4:0]   op = 5'd0;
    logic [W-1:0] x = '0;
    logic [W-1:0] y = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] z;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .x         (x),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z         (z)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] z;
        int           rise;
        string        name;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: on each rising out_valid, compare z and the cycle it appeared.
    logic prev_ov = 1'b0;
    always @(negedge clk) begin
        if (!reset && out_valid && !prev_ov) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_output: got z=%h with nothing outstanding", z);
            end else begin
                check({sb[0].name, " z"}, z, sb[0].z);
                check_int({sb[0].name, " cycle"}, cyc, sb[0].rise);
                void'(sb.pop_front());
            end
        end
        prev_ov <= reset ? 1'b0 : out_valid;
    end

    task automatic wait_ready();
        int g = 0;
        @(negedge clk);
        while (!in_ready && g < 300) begin
            @(negedge clk);
            g++;
        end
        if (!in_ready) check1("in_ready timeout", in_ready, 1'b1);
    endtask

    // lat: spec latency; out_valid is first seen at the negedge lat-1 edges after acceptance.
    task automatic issue(input logic [4:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] ez, input int lat, input string name,
                         input bit push);
        exp_t e;
        wait_ready();
        op       = f;
        x        = a;
        y        = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (push) begin
            e.z    = ez;
            e.rise = cyc + lat - 1;
            e.name = name;
            sb.push_back(e);
        end
    endtask

    task automatic drain();
        int g = 0;
        while ((sb.size() != 0 || out_valid) && g < 300) begin
            @(negedge clk);
            g++;
        end
        if (sb.size() != 0) check_int("drain timeout outstanding", sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen_ov;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check1("reset in_ready", in_ready, 1'b1);
        check1("reset out_valid", out_valid, 1'b0);
        check("reset z", z, 16'h0000);
        reset = 1'b0;

        issue(5'd0, 16'h7FFF, 16'h0001, 16'h8000, 1, "ADD 7FFF+1", 1);
        drain();

        // Asynchronous reset between edges clears z while it holds 8000 in IDLE.
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("async reset z", z, 16'h0000);
        check1("async reset in_ready", in_ready, 1'b1);
        check1("async reset out_valid", out_valid, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        issue(5'd0,  16'hFFFF, 16'h0001, 16'h0000, 1, "ADD FFFF+1", 1);
        issue(5'd1,  16'h0000, 16'h0001, 16'hFFFF, 1, "SUB 0-1", 1);
        issue(5'd2,  16'hF0F0, 16'hFF00, 16'hF000, 1, "AND", 1);
        issue(5'd3,  16'hF0F0, 16'hFF00, 16'hFFF0, 1, "OR", 1);
        issue(5'd4,  16'hF0F0, 16'hFF00, 16'h0FF0, 1, "XOR", 1);
        issue(5'd5,  16'h1234, 16'hFFFF, 16'hEDCB, 1, "NOT", 1);
        issue(5'd6,  16'hFFFF, 16'h0001, 16'h0001, 1, "SLT -1<1", 1);
        issue(5'd6,  16'h0001, 16'hFFFF, 16'h0000, 1, "SLT 1<-1", 1);
        issue(5'd11, 16'h1234, 16'h5678, 16'h0000, 1, "op 11", 1);
        issue(5'd31, 16'hFFFF, 16'hFFFF, 16'h0000, 1, "op 31", 1);

        issue(5'd7,  16'h0001, 16'h000F, 16'h8000, 16, "SHL 1 by 15", 1);
        issue(5'd9,  16'h8000, 16'h0004, 16'hF800, 5,  "SRA 8000 by 4", 1);
        issue(5'd9,  16'h4000, 16'h0001, 16'h2000, 2,  "SRA 4000 by 1", 1);
        issue(5'd8,  16'h8000, 16'h0014, 16'h0800, 5,  "SHR by 0x14", 1);
        issue(5'd7,  16'h1234, 16'h0010, 16'h1234, 1,  "SHL by 0x10", 1);
        issue(5'd8,  16'hABCD, 16'h0000, 16'hABCD, 1,  "SHR by 0", 1);

        issue(5'd10, 16'h0012, 16'h0034, 16'h03A8, 17, "MUL 12*34 inflight", 1);
        op = 5'd0;
        x  = 16'hFFFF;
        y  = 16'hFFFF;
        issue(5'd10, 16'hFFFF, 16'hFFFF, 16'h0001, 17, "MUL FFFF*FFFF", 1);
        issue(5'd10, 16'h0003, 16'h0000, 16'h0000, 17, "MUL 3*0", 1);
        drain();

        // Backpressure: result held for 5 cycles while stray in_valid pulses arrive.
        out_ready = 1'b0;
        issue(5'd0, 16'h0001, 16'h0002, 16'h0003, 1, "ADD backpressure", 1);
        begin
            int g = 0;
            while (!out_valid && g < 50) begin
                @(negedge clk);
                g++;
            end
        end
        for (int i = 0; i < 5; i++) begin
            check1("bp out_valid", out_valid, 1'b1);
            check1("bp in_ready", in_ready, 1'b0);
            check("bp z", z, 16'h0003);
            op       = 5'd0;
            x        = 16'h0009;
            y        = 16'h0009;
            in_valid = (i % 2 == 1);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check1("after release in_ready", in_ready, 1'b1);
        check1("after release out_valid", out_valid, 1'b0);
        drain();

        // Reset in the middle of a multiply: its result must never appear.
        issue(5'd10, 16'h0012, 16'h0034, 16'h0000, 17, "MUL aborted", 0);
        repeat (7) @(posedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        reset   = 1'b0;
        seen_ov = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (out_valid) seen_ov = 1'b1;
        end
        check1("aborted MUL no out_valid", seen_ov, 1'b0);

        issue(5'd0, 16'h0002, 16'h0003, 16'h0005, 1, "ADD after reset", 1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
